// File: rtl/int_controller_pkg.sv
// int_controller_pkg: shared CP0/exception definitions
//   NUM_IRQ       - number of hardware interrupt lines
//   ADDR_*        - interrupt controller config register selects
//   exc_code_t    - exception cause codes
//   prio_idx()    - index of highest set line, 0 when none
package int_controller_pkg;
   localparam int NUM_IRQ = 6;
   localparam logic [1:0] ADDR_MODE    = 2'd0;
   localparam logic [1:0] ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] ADDR_PENDING = 2'd2;
   localparam logic [1:0] ADDR_IRQ_ID  = 2'd3;
   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_t;
   function automatic logic [2:0] prio_idx(input logic [NUM_IRQ-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < NUM_IRQ; i++) if (v[i]) r = 3'(i);
      return r;
   endfunction
endpackage

// File: rtl/int_controller_irq_sync.sv
// irq_sync: single-bit multi-flop synchronizer with async reset
//   clk, rst - clock, async active-high reset
//   d        - asynchronous input
//   q        - synchronized output (last stage)
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] ff;
   always_ff @(posedge clk or posedge rst)
      if (rst) ff <= '0;
      else     ff <= {ff[SYNC_STAGES-2:0], d};
   assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/int_controller.sv
// int_controller: 6-line edge/level interrupt controller with priority ID
//   clk, rst            - clock, async active-high reset
//   irq_in              - asynchronous interrupt requests (bit 5 highest)
//   int_reg             - pending & enabled lines to the exception handler
//   int_ack/_line       - acknowledge pulse and line index from WB
//   cfg_we/addr/wdata   - config write port (MODE, ENABLE, PENDING W1C)
//   cfg_rdata           - combinational config read data
module int_controller
   import int_controller_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [NUM_IRQ-1:0] int_reg,
   input  logic               int_ack,
   input  logic [2:0]         int_ack_line,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata
);
   logic [NUM_IRQ-1:0] sync_out, sync_prev, mode, enable, pending;
   logic [NUM_IRQ-1:0] wd, edge_set, ack_clr, w1c, mode_rise, pend_n;
   logic               mode_we, enable_we, unused_wdata;
   genvar g;
   generate
      for (g = 0; g < NUM_IRQ; g++) begin : g_sync
         irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (irq_in[g]),
            .q   (sync_out[g])
         );
      end
   endgenerate
   assign wd           = cfg_wdata[NUM_IRQ-1:0];
   assign unused_wdata = ^cfg_wdata[31:NUM_IRQ];
   assign mode_we      = cfg_we && cfg_addr == ADDR_MODE;
   assign enable_we    = cfg_we && cfg_addr == ADDR_ENABLE;
   assign edge_set     = sync_out & ~sync_prev & mode;
   assign ack_clr      = (int_ack && int_ack_line < 3'd6) ? 6'b1 << int_ack_line : '0;
   assign w1c          = (cfg_we && cfg_addr == ADDR_PENDING) ? wd : '0;
   // a line switching level->edge starts with a clean pending bit
   assign mode_rise    = mode_we ? wd & ~mode : '0;
   // edge lines: set beats clear; level lines: plain copy of sync_out
   assign pend_n       = (mode & (edge_set | (pending & ~(ack_clr | w1c))))
                       | (~mode & sync_out & ~mode_rise);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_prev <= '0;
         mode      <= '0;
         enable    <= '0;
         pending   <= '0;
      end else begin
         sync_prev <= sync_out;
         mode      <= mode_we ? wd : mode;
         enable    <= enable_we ? wd : enable;
         pending   <= pend_n;
      end
   assign int_reg   = pending & enable;
   assign cfg_rdata = cfg_addr == ADDR_MODE    ? {26'b0, mode}
                    : cfg_addr == ADDR_ENABLE  ? {26'b0, enable}
                    : cfg_addr == ADDR_PENDING ? {26'b0, pending}
                    : {24'b0, |int_reg, 4'b0, prio_idx(int_reg)};
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed self-checking bench for int_controller
module tb_int_controller;
   logic        clk = 0, rst = 0, int_ack = 0, cfg_we = 0;
   logic [5:0]  irq_in = 0;
   logic [2:0]  int_ack_line = 0;
   logic [1:0]  cfg_addr = 0;
   logic [31:0] cfg_wdata = 0;
   logic [5:0]  int_reg;
   logic [31:0] cfg_rdata;
   int          checks = 0, errors = 0;

   int_controller #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .irq_in       (irq_in),
      .int_reg      (int_reg),
      .int_ack      (int_ack),
      .int_ack_line (int_ack_line),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_rdata    (cfg_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      chk(tag, cfg_rdata, exp);
   endtask

   task automatic pulse(input logic [5:0] m);
      irq_in = m;
      tick();
      irq_in = 0;
      tick();
      tick();
   endtask

   task automatic ack(input logic [2:0] line);
      int_ack = 1; int_ack_line = line;
      tick();
      int_ack = 0;
   endtask

   initial begin
      irq_in = 6'h3F;
      #1 rst = 1;
      #1 chk("rst_int_reg_async", {26'b0, int_reg}, 0);
      repeat (3) tick();
      chk("rst_int_reg", {26'b0, int_reg}, 0);
      for (int a = 0; a < 4; a++) rd($sformatf("rst_rdata%0d", a), 2'(a), 0);
      rst = 0;
      repeat (3) tick();
      chk("post_rst_masked", {26'b0, int_reg}, 0);
      rd("post_rst_level_pend", 2'd2, 32'h3F);
      irq_in = 0;
      repeat (3) tick();
      rd("level_pend_clear", 2'd2, 0);

      cfg_write(2'd0, 32'hFFFF_FF3F);
      cfg_write(2'd1, 32'h3F);
      rd("mode_rd", 2'd0, 32'h3F);
      rd("enable_rd", 2'd1, 32'h3F);
      irq_in = 6'h04;
      tick();
      irq_in = 0;
      chk("edge_lat_n", {26'b0, int_reg}, 0);
      tick();
      chk("edge_lat_n1", {26'b0, int_reg}, 0);
      tick();
      chk("edge_lat_n2", {26'b0, int_reg}, 32'h04);
      repeat (3) tick();
      chk("edge_hold", {26'b0, int_reg}, 32'h04);
      rd("irq_id_82", 2'd3, 32'h82);
      cfg_write(2'd3, 32'h3F);
      rd("irq_id_wr_ignored", 2'd0, 32'h3F);
      pulse(6'h04);
      chk("edge_collapse", {26'b0, int_reg}, 32'h04);
      ack(3'd2);
      chk("ack_clears_2", {26'b0, int_reg}, 0);
      rd("irq_id_none", 2'd3, 0);

      pulse(6'h08);
      chk("pend3_set", {26'b0, int_reg}, 32'h08);
      irq_in = 6'h08;
      tick();
      irq_in = 0;
      tick();
      ack(3'd3);
      chk("set_beats_ack", {26'b0, int_reg}, 32'h08);
      ack(3'd3);
      chk("ack_alone_3", {26'b0, int_reg}, 0);

      pulse(6'h10);
      ack(3'd6);
      chk("ack_line6_ignored", {26'b0, int_reg}, 32'h10);
      ack(3'd7);
      chk("ack_line7_ignored", {26'b0, int_reg}, 32'h10);
      pulse(6'h01);
      cfg_write(2'd2, 32'h10);
      chk("w1c_partial", {26'b0, int_reg}, 32'h01);
      cfg_write(2'd2, 32'h01);
      chk("w1c_clear", {26'b0, int_reg}, 0);

      cfg_write(2'd0, 0);
      cfg_write(2'd1, 32'h01);
      for (int j = 1; j <= 9; j++) begin
         irq_in = (j <= 5) ? 6'h01 : 6'h00;
         cfg_we = (j == 4); cfg_addr = 2'd2; cfg_wdata = 32'h01;
         tick();
         cfg_we = 0;
         chk($sformatf("level_t%0d", j), {26'b0, int_reg}, (j >= 3 && j <= 7) ? 32'h01 : 32'h00);
      end

      irq_in = 6'h21;
      repeat (3) tick();
      chk("prio_masked", {26'b0, int_reg}, 32'h01);
      rd("irq_id_80", 2'd3, 32'h80);
      cfg_write(2'd1, 32'h3F);
      chk("prio_unmasked", {26'b0, int_reg}, 32'h21);
      rd("irq_id_85", 2'd3, 32'h85);
      cfg_write(2'd0, 32'h01);
      rd("mode_rise_clears", 2'd2, 32'h20);
      tick();
      rd("no_edge_on_held", 2'd2, 32'h20);
      irq_in = 0;

      cfg_write(2'd0, 32'h3F);
      pulse(6'h3F);
      chk("all_pending", {26'b0, int_reg}, 32'h3F);
      #2 rst = 1;
      #1 chk("async_rst_int_reg", {26'b0, int_reg}, 0);
      rd("async_rst_pend", 2'd2, 0);
      tick();
      rst = 0;
      tick();
      rd("rst_mode_cleared", 2'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops per irq line (legal range 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port irq_in  input  6  external interrupt requests, asynchronous to clk; bit 5 = highest priority.
REQ-005 SHALL have port int_reg  output  6  enabled pending lines presented to the exception handler (feeds CAUSE hardware-pending field).
REQ-006 SHALL have port int_ack  input  1  one-cycle pulse from WB when an interrupt exception is taken.
REQ-007 SHALL have port int_ack_line  input  3  index (0..5) of the line being acknowledged; valid only with int_ack.
REQ-008 SHALL have port cfg_we  input  1  config write strobe.
REQ-009 SHALL have port cfg_addr  input  2  register select: 0 MODE, 1 ENABLE, 2 PENDING, 3 IRQ_ID.
REQ-010 SHALL have port cfg_wdata  input  32  write data; only bits [5:0] used.
REQ-011 SHALL have port cfg_rdata  output  32  combinational read data for cfg_addr.

Function
REQ-012 Each irq_in bit SHALL pass through SYNC_STAGES flops; sync_out = last stage; a further flop holds sync_prev.
REQ-013 MODE bit=1 SHALL make the line edge-triggered; MODE bit=0 SHALL make it level-sensitive.
REQ-014 Edge line: pending bit SHALL set on the clock after sync_out & ~sync_prev is seen; it stays set until cleared.
REQ-015 Level line: pending bit SHALL be registered copy of sync_out each cycle; ack and W1C SHALL have no effect on it.
REQ-016 Latency: irq_in rising before edge N (SYNC_STAGES=2) SHALL appear on int_reg after edge N+2.
REQ-017 int_reg SHALL equal PENDING & ENABLE combinationally; disabled lines keep pending state but are masked.
REQ-018 int_ack SHALL clear pending[int_ack_line] for an edge line on the next edge; int_ack_line > 5 SHALL be ignored.
REQ-019 Write to PENDING SHALL clear each edge-line bit where cfg_wdata bit=1 (write-1-to-clear); 0 bits unchanged.
REQ-020 Simultaneous set and clear (ack or W1C) of the same bit in one cycle: set SHALL win.
REQ-021 Writes to MODE and ENABLE SHALL take effect on the next edge; a MODE 0->1 write SHALL clear that line's pending bit in the same edge.
REQ-022 IRQ_ID read SHALL return {24'b0, valid, 4'b0, idx[2:0]}: valid=|int_reg, idx = highest set index in int_reg, idx=0 when not valid.
REQ-023 MODE/ENABLE/PENDING reads SHALL return {26'b0, reg[5:0]}; IRQ_ID writes SHALL be ignored.
REQ-024 Two edges on one line before acknowledgment SHALL collapse into one pending event (no counting).

Reset
REQ-025 rst SHALL asynchronously clear all synchronizer flops, sync_prev, PENDING, ENABLE, and MODE to 0 (all lines level, all masked).
REQ-026 During and immediately after reset, int_reg SHALL be 6'b0; a high irq_in at reset release SHALL NOT produce a spurious edge (sync_prev reset to 0 but pending requires ENABLE set later; edge detection valid only after sync chain filled).
REQ-027 Reset asserted mid-operation SHALL drop all pending interrupts with no ack required.

Structure
REQ-028 Register address constants (MODE, ENABLE, PENDING, IRQ_ID) and line count 6 SHALL live in the shared CP0/exception define package alongside exception code constants.
REQ-029 One sub-module, irq_sync (single-bit SYNC_STAGES synchronizer, async reset), SHALL be instantiated 6 times; priority encoder and registers stay inline.

Verification
REQ-030 Reset: hold rst with irq_in=6'h3F -> int_reg=0, cfg_rdata=0 for all addresses.
REQ-031 Edge latency: MODE=6'h3F, ENABLE=6'h3F; pulse irq_in[2] one cycle before edge N -> int_reg=6'h04 after edge N+2, stays after irq_in drops; IRQ_ID=0x82.
REQ-032 Ack vs new edge: pending[3] set, int_ack with int_ack_line=3 in same cycle new edge on line 3 reaches detector -> pending[3] remains 1; ack alone next time -> int_reg[3]=0.
REQ-033 Level mode: MODE=0, ENABLE=6'h01; irq_in[0] high 5 cycles -> int_reg[0] high for 5 cycles delayed by 3; W1C 0x01 during -> no effect.
REQ-034 Priority/mask: pending=6'h21, ENABLE=6'h01 -> int_reg=6'h01, IRQ_ID=0x80; ENABLE=6'h3F -> IRQ_ID=0x85.
REQ-035 Async reset mid-operation: assert rst between edges with pending=6'h3F -> int_reg=0 immediately, before next clk edge.
